// File: rtl/reg_dump_unit.sv
// reg_dump_unit: sweeps every bank register through one read port and streams it MSB-byte-first over valid/ready
module reg_dump_unit #(
  parameter int NB_DATA = 32,
  parameter int NB_REG  = 5
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  output logic [NB_REG-1:0] o_read_reg,
  input  logic [NB_DATA-1:0] i_reg_data,
  output logic [7:0]        o_tx_data,
  output logic              o_tx_valid,
  input  logic              i_tx_ready,
  output logic              o_busy,
  output logic              o_done
);
  localparam int B = NB_DATA / 8;
  localparam int NB_BCNT = (B > 1) ? $clog2(B) : 1;
  localparam logic [NB_BCNT-1:0] BCNT_LAST = NB_BCNT'(B - 1);
  typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_t;
  state_t state_q, state_d;
  logic [NB_REG-1:0] idx_q, idx_d;
  logic [NB_DATA-1:0] sh_q, sh_d;
  logic [NB_BCNT-1:0] bcnt_q, bcnt_d;
  logic hs, last_byte, last_reg;
  // next-state: latch word in LOAD, shift out one byte per handshake, advance register after the last byte
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    sh_d = sh_q;
    bcnt_d = bcnt_q;
    hs = (state_q == SEND) && i_tx_ready;
    last_byte = bcnt_q == BCNT_LAST;
    last_reg = &idx_q;
    case (state_q)
      IDLE: if (i_start) begin
        idx_d = '0;
        state_d = LOAD;
      end
      LOAD: begin
        sh_d = i_reg_data;
        bcnt_d = '0;
        state_d = SEND;
      end
      SEND: if (hs) begin
        if (!last_byte) begin
          sh_d = sh_q << 8;
          bcnt_d = bcnt_q + 1'b1;
        end else if (!last_reg) begin
          idx_d = idx_q + 1'b1;
          state_d = LOAD;
        end else state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state registers with synchronous reset that also aborts a dump in flight
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      idx_q <= '0;
      sh_q <= '0;
      bcnt_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      sh_q <= sh_d;
      bcnt_q <= bcnt_d;
    end
  end
  assign o_read_reg = idx_q;
  assign o_tx_data = sh_q[NB_DATA-1 -: 8];
  assign o_tx_valid = state_q == SEND;
  assign o_busy = state_q != IDLE;
  assign o_done = state_q == DONE;
endmodule

// File: tb/tb_reg_dump_unit.sv
// tb_reg_dump_unit: scoreboard bench with a word-level bank model and randomized back-pressure
module tb_reg_dump_unit;
  localparam int N = 32, B = 4, N2 = 8, B2 = 2;
  logic clk = 0, rst = 1, start = 0, ready = 1, start2 = 0;
  logic [4:0] rreg;
  logic [31:0] rdata;
  logic [7:0] txd, txd2;
  logic txv, busy, done, txv2, busy2, done2;
  logic [2:0] rreg2;
  logic [15:0] rdata2;
  logic [31:0] bank [N];
  logic [15:0] bank2 [N2];
  assign rdata = bank[rreg];
  assign rdata2 = bank2[rreg2];
  always #5 clk = ~clk;

  reg_dump_unit #(.NB_DATA(32), .NB_REG(5)) dut (
    .i_clk(clk), .i_reset(rst), .i_start(start), .o_read_reg(rreg), .i_reg_data(rdata),
    .o_tx_data(txd), .o_tx_valid(txv), .i_tx_ready(ready), .o_busy(busy), .o_done(done));
  reg_dump_unit #(.NB_DATA(16), .NB_REG(3)) dut2 (
    .i_clk(clk), .i_reset(rst), .i_start(start2), .o_read_reg(rreg2), .i_reg_data(rdata2),
    .o_tx_data(txd2), .o_tx_valid(txv2), .i_tx_ready(1'b1), .o_busy(busy2), .o_done(done2));

  int n_cmp = 0, n_bad = 0, cyc = 0, mode = 0;
  logic [7:0] exp_q[$], exp2[$];
  int byte_cnt, done_cnt, done_cyc, load_cyc, st_cyc;
  int cnt2 = 0, done2_cnt = 0, done2_cyc = 0, load2 = 0;
  logic load_seen = 0, seen2 = 0, prev_stall = 0, prev_done = 0;
  logic [7:0] prev_d;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ready driver: 0 high, 1 toggle, 2 random, 3 held low
  initial forever begin
    @(posedge clk);
    #1;
    ready = (mode == 0) ? 1'b1 : (mode == 1) ? ~ready : (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  // monitor for the default-size DUT
  initial forever begin
    @(negedge clk);
    if (rst) begin
      prev_stall = 0;
      prev_done = 0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", txv, 1);
        chk("stall_data", txd, prev_d);
      end
      if (prev_done) begin
        chk("done_one_cycle", done, 0);
        chk("busy_after_done", busy, 0);
      end
      if (txv && ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL extra_byte: got %0h, expected no byte", txd);
        end else chk("byte", txd, exp_q.pop_front());
        byte_cnt++;
      end
      if (busy && !load_seen) begin
        load_seen = 1;
        load_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_stall = txv && !ready;
      prev_d = txd;
      prev_done = done;
    end
  end

  // monitor for the 16-bit / 8-register DUT
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (txv2) begin
        if (exp2.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL extra_byte2: got %0h, expected no byte", txd2);
        end else chk("byte2", txd2, exp2.pop_front());
        cnt2++;
      end
      if (busy2 && !seen2) begin
        seen2 = 1;
        load2 = cyc;
      end
      if (done2) begin
        done2_cnt++;
        done2_cyc = cyc;
      end
    end
  end

  task automatic start_dump(input int ovr, input logic [31:0] ovr_val);
    for (int r = 0; r < N; r++) begin
      logic [31:0] w;
      w = (r == ovr) ? ovr_val : bank[r];
      for (int b = B - 1; b >= 0; b--) exp_q.push_back(w[8*b +: 8]);
    end
    load_seen = 0;
    done_cnt = 0;
    byte_cnt = 0;
    start = 1;
    tick(1);
    start = 0;
    st_cyc = cyc;
  endtask

  task automatic wait_done(input logic chk_lat);
    for (int t = 0; t < 5000 && !(done_cnt > 0 && !busy); t++) tick(1);
    chk("dump_finished", done_cnt > 0 && !busy, 1);
    chk("done_count", done_cnt, 1);
    chk("byte_count", byte_cnt, N * B);
    chk("queue_empty", exp_q.size(), 0);
    chk("start_to_load", load_cyc, st_cyc);
    if (chk_lat) chk("done_latency", done_cyc - load_cyc, N * (1 + B));
  endtask

  task automatic preload();
    for (int i = 0; i < N; i++) bank[i] = 32'h11223300 + i;
  endtask

  initial begin
    preload();
    for (int i = 0; i < N2; i++) bank2[i] = 16'($urandom);
    tick(2);
    chk("rst_valid", txv, 0);
    chk("rst_busy", busy, 0);
    chk("rst_read_reg", rreg, 0);
    chk("rst_data", txd, 0);
    chk("rst_done", done, 0);
    rst = 0;
    tick(2);

    mode = 0;
    start_dump(-1, 0);
    wait_done(1);

    mode = 1;
    start_dump(-1, 0);
    wait_done(0);

    mode = 0;
    start_dump(-1, 0);
    for (int t = 0; t < 500 && byte_cnt < 40; t++) tick(1);
    start = 1;
    tick(1);
    start = 0;
    for (int t = 0; t < 500 && !done; t++) tick(1);
    chk("reached_done", done, 1);
    start = 1;
    tick(1);
    start = 0;
    chk("ignored_start_done", done_cnt, 1);
    chk("ignored_start_bytes", byte_cnt, N * B);
    chk("idle_after_done", busy, 0);
    mode = 2;
    for (int i = 0; i < N; i++) bank[i] = $urandom;
    start_dump(-1, 0);
    wait_done(0);

    mode = 0;
    preload();
    start_dump(-1, 0);
    for (int t = 0; t < 500 && byte_cnt < 7 * B + 2; t++) tick(1);
    chk("mid_reg", rreg, 7);
    mode = 3;
    ready = 0;
    rst = 1;
    exp_q.delete();
    tick(1);
    chk("abort_valid", txv, 0);
    chk("abort_busy", busy, 0);
    chk("abort_read_reg", rreg, 0);
    chk("abort_done", done, 0);
    rst = 0;
    mode = 0;
    tick(3);
    chk("abort_no_done", done_cnt, 0);
    mode = 2;
    for (int i = 0; i < N; i++) bank[i] = $urandom;
    start_dump(-1, 0);
    wait_done(0);

    mode = 0;
    preload();
    start_dump(5, 32'hDEADBEEF);
    for (int t = 0; t < 500 && !(rreg == 5 && busy && !txv); t++) tick(1);
    chk("found_load5", rreg == 5 && busy && !txv, 1);
    @(negedge clk) bank[5] = 32'hDEADBEEF;
    wait_done(1);
    preload();
    start_dump(-1, 0);
    for (int t = 0; t < 500 && !(rreg == 5 && txv); t++) tick(1);
    chk("found_send5", rreg == 5 && txv, 1);
    @(negedge clk) bank[5] = 32'hDEADBEEF;
    wait_done(1);

    for (int r = 0; r < N2; r++) for (int b = B2 - 1; b >= 0; b--) exp2.push_back(bank2[r][8*b +: 8]);
    start2 = 1;
    tick(1);
    start2 = 0;
    for (int t = 0; t < 100 && !(done2_cnt > 0 && !busy2); t++) tick(1);
    chk("small_finished", done2_cnt > 0 && !busy2, 1);
    chk("small_bytes", cnt2, N2 * B2);
    chk("small_done_count", done2_cnt, 1);
    chk("small_done_latency", done2_cyc - load2, N2 * (1 + B2));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
